// File: rtl/mmc_pkg.sv
// Shared definitions for the matrix-multiply controller and its result reader.
package mmc_pkg;

    localparam int N       = 32;
    localparam int DW      = 21;
    localparam int AW      = 10;
    localparam int C_DEPTH = N * N;
    localparam int RC_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } mmc_state_e;

    // One streamed result element.
    // The row and column travel with the data word.
    typedef struct packed {
        logic [DW-1:0]   data;
        logic [RC_W-1:0] row;
        logic [RC_W-1:0] col;
        logic            last;
    } rd_elem_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that catches C-memory read returns and presents the head element.
// The head always sits in slot0, so the stream outputs come straight from a register.
module rd_skid_buf
    import mmc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  rd_elem_t push_elem_i,
    input  logic     pop_i,
    output rd_elem_t head_o,
    output logic [1:0] count_o
);

    rd_elem_t   slot0_q, slot0_d;
    rd_elem_t   slot1_q, slot1_d;
    logic [1:0] count_q, count_d;

    // Next-state for the shift-style FIFO. Pop is only requested while count_q is nonzero.
    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block leaves a value unassigned and infers a latch.
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = push_elem_i;
                else                 slot1_d = push_elem_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_elem_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_elem_i;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two slots are reset even though they hold data.
            // The stream outputs read slot0 directly and must show zero after reset.
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of statement order.
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/mmc_result_reader.sv
// Drains the N x N result matrix from C memory and streams it row-major over valid/ready.
// Reads are issued only when the skid buffer can absorb them.
// This hides the 1-cycle memory latency and any downstream stall.
module mmc_result_reader
    import mmc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_nce,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_do,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_row,
    output logic [4:0]    out_col,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [AW:0]   END_PTR   = (AW+1)'(C_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(C_DEPTH - 1);

    mmc_state_e    state_q;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          in_flight_q;
    logic [AW-1:0] flight_addr_q;
    logic          done_q;

    rd_elem_t   head;
    rd_elem_t   push_elem;
    logic [1:0] buf_count;
    logic [2:0] occ_after_pop;
    logic       pop;
    logic       issue;

    assign pop = out_valid && out_ready;

    // Occupancy left once this cycle's pop has gone, counting the read still in flight.
    // Issuing while two entries are held is also refused.
    // This keeps the buffer from ever reaching a third element.
    assign occ_after_pop = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue         = (state_q == RUN) && (buf_count != 2'd2) && (occ_after_pop < 3'd2);
    assign rd_ptr_d      = rd_ptr_q + 1'b1;

    // Control FSM, read pointer, in-flight tracking and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            in_flight_q   <= 1'b0;
            flight_addr_q <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            in_flight_q <= issue;
            if (issue) flight_addr_q <= rd_ptr_q[AW-1:0];
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        rd_ptr_q <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_ptr_q <= rd_ptr_d;
                        if (rd_ptr_d == END_PTR) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && head.last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The returning word is tagged with the address it was read from, not with rd_ptr.
    assign push_elem.data = mem_do;
    assign push_elem.row  = flight_addr_q[AW-1:RC_W];
    assign push_elem.col  = flight_addr_q[RC_W-1:0];
    assign push_elem.last = (flight_addr_q == LAST_ADDR);

    rd_skid_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_flight_q),
        .push_elem_i (push_elem),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (buf_count)
    );

    // busy also covers the done cycle.
    // A start arriving with done is accepted without busy dropping between drains.
    assign busy      = (state_q != IDLE) || done_q;
    assign done      = done_q;
    assign mem_addr  = rd_ptr_q[AW-1:0];
    assign mem_nce   = ~issue;
    assign mem_wen   = 1'b1;
    assign out_valid = (buf_count != 2'd0);
    assign out_data  = head.data;
    assign out_row   = head.row;
    assign out_col   = head.col;
    assign out_last  = head.last && out_valid;

endmodule
